// File: rtl/dma_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter_pkg
//   Definitions shared by the DMA bus arbiter and the DMA engine: the arbiter
//   state encoding, the transfer-counter word size and the grant-watchdog
//   counter width.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package dma_bus_arbiter_pkg;

    // Word size shared with the DMA engine; default width of xfer_cnt.
    localparam int WORD_SIZE = 16;

    // Grant watchdog counter width (timeouts up to 255 cycles).
    localparam int WD_WIDTH = 8;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_CMD,
        ARB_WAIT_BR,
        ARB_GRANT,
        ARB_RELEASE
    } arb_state_t;

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter_if
//   Groups the CPU / DMA / bus-mux handshake signals around the arbiter.
//   Signals:
//     dev_irq, cpu_mem_busy, BR, dma_irq       driven by the environment
//     cmd, BG, cpu_stall, done_irq,
//     err_timeout, xfer_cnt[CNT_WIDTH]         driven by the arbiter
//   Modports:
//     master : environment side (CPU core, DMA controller, device)
//     slave  : arbiter side
// -----------------------------------------------------------------------------
interface dma_bus_arbiter_if
    import dma_bus_arbiter_pkg::*;
#(
    parameter int CNT_WIDTH = WORD_SIZE
);
    logic                 dev_irq;
    logic                 cpu_mem_busy;
    logic                 BR;
    logic                 dma_irq;
    logic                 cmd;
    logic                 BG;
    logic                 cpu_stall;
    logic                 done_irq;
    logic                 err_timeout;
    logic [CNT_WIDTH-1:0] xfer_cnt;

    modport master (
        output dev_irq, cpu_mem_busy, BR, dma_irq,
        input  cmd, BG, cpu_stall, done_irq, err_timeout, xfer_cnt
    );

    modport slave (
        input  dev_irq, cpu_mem_busy, BR, dma_irq,
        output cmd, BG, cpu_stall, done_irq, err_timeout, xfer_cnt
    );

endinterface

// File: rtl/dma_bus_arbiter_grant_watchdog.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter_grant_watchdog
//   Counts consecutive grant cycles and flags when the grant has lasted
//   TIMEOUT cycles.
//   Ports:
//     CLK      in   rising-edge clock
//     reset_n  in   synchronous active-low reset
//     clr      in   clear counter (held while not granting)
//     en       in   count this cycle (high while granting)
//     expired  out  this is the TIMEOUT-th consecutive grant cycle
// -----------------------------------------------------------------------------
module dma_bus_arbiter_grant_watchdog
    import dma_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WD_WIDTH-1:0] LIMIT = WD_WIDTH'(TIMEOUT - 1);

    logic [WD_WIDTH-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + WD_WIDTH'(1);
    end

    // Counter reads 0 in the first grant cycle, so equality with TIMEOUT-1
    // marks the TIMEOUT-th grant cycle.
    assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/dma_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dma_bus_arbiter
//   CPU-side bus controller for the DMA engine. Converts a device interrupt
//   into a one-cycle DMA command, grants the memory bus to the DMA once the
//   CPU is idle on the bus, stalls the CPU while the DMA owns the bus, and
//   reclaims the bus on DMA-done, early BR drop or grant timeout.
//   Parameters:
//     GRANT_TIMEOUT  max consecutive BG cycles before forced reclaim (2..255)
//     CNT_WIDTH      width of the completed-transfer counter
//   Ports:
//     CLK      in  rising-edge clock
//     reset_n  in  synchronous active-low reset
//     bus      dma_bus_arbiter_if.slave
//              in : dev_irq, cpu_mem_busy, BR, dma_irq
//              out: cmd, BG, cpu_stall, done_irq, err_timeout, xfer_cnt
// -----------------------------------------------------------------------------
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int GRANT_TIMEOUT = 32,
    parameter int CNT_WIDTH     = WORD_SIZE
) (
    input  logic                 CLK,
    input  logic                 reset_n,
    dma_bus_arbiter_if.slave     bus
);

    arb_state_t state, state_n;

    logic                 expired;
    logic                 done_n;
    logic                 err_set;
    logic                 stall_n;

    logic                 cmd_q;
    logic                 bg_q;
    logic                 stall_q;
    logic                 done_q;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    dma_bus_arbiter_grant_watchdog #(
        .TIMEOUT (GRANT_TIMEOUT)
    ) u_grant_watchdog (
        .CLK     (CLK),
        .reset_n (reset_n),
        .clr     (state != ARB_GRANT),
        .en      (state == ARB_GRANT),
        .expired (expired)
    );

    always_ff @(posedge CLK) begin
        if (!reset_n)
            state <= ARB_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        err_set = 1'b0;
        case (state)
            ARB_IDLE:    if (bus.dev_irq) state_n = ARB_CMD;
            ARB_CMD:     state_n = ARB_WAIT_BR;
            ARB_WAIT_BR: if (bus.BR && !bus.cpu_mem_busy) state_n = ARB_GRANT;
            ARB_GRANT: begin
                // Completion has priority over a coinciding timeout.
                if (bus.dma_irq) begin
                    state_n = ARB_RELEASE;
                    done_n  = 1'b1;
                end else if (expired) begin
                    state_n = ARB_RELEASE;
                    err_set = 1'b1;
                end else if (!bus.BR) begin
                    state_n = ARB_RELEASE;
                end
            end
            ARB_RELEASE: state_n = ARB_IDLE;
            default:     state_n = ARB_IDLE;
        endcase

        // Stall while the DMA owns or is about to own the bus; in WAIT_BR the
        // stall follows a registered copy of BR so no input reaches an output
        // combinationally.
        stall_n = (state_n == ARB_GRANT) || (state_n == ARB_RELEASE) ||
                  ((state_n == ARB_WAIT_BR) && bus.BR);
    end

    // All outputs are flops loaded from the next-state decode, so each one
    // lines up with the state it belongs to.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            cmd_q   <= 1'b0;
            bg_q    <= 1'b0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cmd_q   <= (state_n == ARB_CMD);
            bg_q    <= (state_n == ARB_GRANT);
            stall_q <= stall_n;
            done_q  <= done_n;
            if (err_set)
                err_q <= 1'b1;
            if (done_n)
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.cmd         = cmd_q;
    assign bus.BG          = bg_q;
    assign bus.cpu_stall   = stall_q;
    assign bus.done_irq    = done_q;
    assign bus.err_timeout = err_q;
    assign bus.xfer_cnt    = cnt_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_bus_arbiter
//   Directed cycle-exact scenarios followed by randomized transfers. Each
//   random transfer is summarised by a transaction-level model: how many BG
//   cycles it lasts, whether it completes, whether it times out, and what the
//   wrapped transfer count becomes.
// -----------------------------------------------------------------------------
module tb_dma_bus_arbiter;

    localparam int TO = 8;
    localparam int CW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks    = 0;
    int   failures  = 0;
    int   stall_bad = 0;
    int   m_cnt     = 0;
    int   m_err     = 0;

    dma_bus_arbiter_if #(.CNT_WIDTH(CW)) bus();

    dma_bus_arbiter #(
        .GRANT_TIMEOUT (TO),
        .CNT_WIDTH     (CW)
    ) dut (
        .CLK     (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic d, input logic b, input logic br, input logic dm);
        bus.dev_irq      = d;
        bus.cpu_mem_busy = b;
        bus.BR           = br;
        bus.dma_irq      = dm;
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, bus.cmd, bus.BG, bus.cpu_stall, bus.done_irq,
                bus.err_timeout, 1'b0, bus.xfer_cnt};
    endfunction

    // Transaction-level expectation. mode 0: DMA signals done in BG cycle L;
    // mode 1: DMA drops BR in BG cycle L; mode 2: DMA never finishes.
    task automatic model_xfer(input int mode, input int L,
                              output int bg, output int done, output int err);
        bg   = (mode == 2) ? TO : ((L < TO) ? L : TO);
        done = (mode == 0 && L <= TO) ? 1 : 0;
        case (mode)
            0:       err = (L > TO)  ? 1 : 0;
            1:       err = (L >= TO) ? 1 : 0;
            default: err = 1;
        endcase
    endtask

    // Drives one full transfer with a reactive DMA model and counts what the
    // arbiter produced. Ends in the RELEASE cycle.
    task automatic run_xfer(input int busy_n, input int mode, input int L,
                            output int bg, output int done);
        int g;
        bit rel;
        g = 0; rel = 0; bg = 0; done = 0;
        set_in(0, 0, 0, 0);
        step;
        bus.dev_irq = 1'b1;
        step;
        chk("x_cmd", 32'(bus.cmd), 1);
        bus.dev_irq = 1'b0;
        step;
        bus.BR           = 1'b1;
        bus.cpu_mem_busy = (busy_n > 0);
        bus.dma_irq      = 1'($urandom_range(0, 1));
        for (int c = 0; c < 40 && !rel; c++) begin
            step;
            if (bus.BG) g++;
            else if (g > 0) rel = 1;
            bg   += int'(bus.BG);
            done += int'(bus.done_irq);
            if ((bus.BG || rel) && !bus.cpu_stall) stall_bad++;
            bus.cpu_mem_busy = (c + 1 < busy_n);
            if (rel)
                set_in(0, 0, 0, 0);
            else if (bus.BG) begin
                bus.dma_irq = (mode == 0 && g == L);
                if (mode == 1) bus.BR = (g < L);
            end else
                bus.dma_irq = 1'($urandom_range(0, 1));   // ignored before grant
        end
        chk("x_release_seen", 32'(rel), 1);
    endtask

    initial begin
        int bg, done, e_bg, e_done, e_err, mode, L, bn;
        set_in(0, 0, 0, 0);

        // Reset with inputs toggling.
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step;
            chk("reset_outs", outs(), 0);
        end
        set_in(0, 0, 0, 0);
        rst_n = 1'b1;
        step;
        step;
        chk("idle_outs", outs(), 0);

        // Basic transfer: dev_irq in cycle 0.
        bus.dev_irq = 1'b1;
        step;                                         // cycle 1
        chk("basic_cmd", 32'(bus.cmd), 1);
        chk("basic_cmd_stall", 32'(bus.cpu_stall), 0);
        bus.dev_irq = 1'b0;
        step;                                         // cycle 2
        chk("basic_cmd_once", 32'(bus.cmd), 0);
        chk("basic_bg_c2", 32'(bus.BG), 0);
        bus.BR = 1'b1;
        for (int c = 3; c <= 6; c++) begin
            step;
            chk("basic_bg_high", 32'(bus.BG), 1);
            chk("basic_stall_high", 32'(bus.cpu_stall), 1);
        end
        bus.dma_irq = 1'b1;                           // 4th BG cycle
        step;                                         // cycle 7
        m_cnt = 1;
        chk("basic_bg_low", 32'(bus.BG), 0);
        chk("basic_done", 32'(bus.done_irq), 1);
        chk("basic_release_stall", 32'(bus.cpu_stall), 1);
        chk("basic_xfer_cnt", 32'(bus.xfer_cnt), 1);
        set_in(0, 0, 0, 0);
        step;
        chk("basic_idle_outs", outs(), 32'(m_cnt));

        // CPU busy while BR is up.
        bus.dev_irq = 1'b1;
        step;
        chk("busy_cmd", 32'(bus.cmd), 1);
        bus.dev_irq = 1'b0;
        step;
        chk("busy_wait_nostall", 32'(bus.cpu_stall), 0);
        bus.BR = 1'b1;
        bus.cpu_mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            chk("busy_bg_low", 32'(bus.BG), 0);
            chk("busy_stall", 32'(bus.cpu_stall), 1);
        end
        bus.cpu_mem_busy = 1'b0;
        step;
        chk("busy_grant", 32'(bus.BG), 1);
        bus.dma_irq = 1'b1;
        step;
        m_cnt = 2;
        chk("busy_done", 32'(bus.done_irq), 1);
        chk("busy_xfer_cnt", 32'(bus.xfer_cnt), 2);
        set_in(0, 0, 0, 0);

        // dma_irq coincides with the timeout cycle: completion, no error.
        run_xfer(0, 0, TO, bg, done);
        m_cnt = 3;
        chk("coinc_bg", 32'(bg), TO);
        chk("coinc_done", 32'(done), 1);
        chk("coinc_err", 32'(bus.err_timeout), 0);
        chk("coinc_xfer_cnt", 32'(bus.xfer_cnt), 3);

        // Timeout: BR held, no dma_irq.
        run_xfer(1, 2, 0, bg, done);
        m_err = 1;
        chk("tmo_bg", 32'(bg), TO);
        chk("tmo_done", 32'(done), 0);
        chk("tmo_err", 32'(bus.err_timeout), 1);
        chk("tmo_xfer_cnt", 32'(bus.xfer_cnt), 3);
        repeat (3) step;
        chk("tmo_err_sticky", 32'(bus.err_timeout), 1);

        // Reset in the 2nd BG cycle.
        bus.dev_irq = 1'b1;
        step;
        bus.dev_irq = 1'b0;
        step;
        bus.BR = 1'b1;
        step;
        step;
        chk("mid_bg_2nd", 32'(bus.BG), 1);
        rst_n = 1'b0;
        step;
        chk("mid_rst_bg", 32'(bus.BG), 0);
        chk("mid_rst_stall", 32'(bus.cpu_stall), 0);
        chk("mid_rst_outs", outs(), 0);
        m_cnt = 0;
        m_err = 0;
        set_in(0, 0, 0, 0);
        rst_n = 1'b1;
        step;

        // Five completions on a 2-bit counter wrap to 1.
        for (int i = 0; i < 5; i++) begin
            run_xfer(int'($urandom_range(0, 2)), 0, int'($urandom_range(1, 6)), bg, done);
            chk("wrap_done", 32'(done), 1);
        end
        m_cnt = 5;
        chk("wrap_xfer_cnt", 32'(bus.xfer_cnt), 1);

        // Randomized transfers against the transaction model.
        for (int t = 0; t < 40; t++) begin
            mode = int'($urandom_range(0, 2));
            L    = int'($urandom_range(1, 10));
            bn   = int'($urandom_range(0, 3));
            model_xfer(mode, L, e_bg, e_done, e_err);
            run_xfer(bn, mode, L, bg, done);
            m_cnt += e_done;
            if (e_err != 0) m_err = 1;
            chk("rnd_bg", 32'(bg), 32'(e_bg));
            chk("rnd_done", 32'(done), 32'(e_done));
            chk("rnd_err", 32'(bus.err_timeout), 32'(m_err));
            chk("rnd_xfer_cnt", 32'(bus.xfer_cnt), 32'(m_cnt % 4));
        end
        chk("stall_during_grant", 32'(stall_bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
